// File: rtl/id_inst_queue_if.sv
// Handshake bundle between the IF-side producer, the instruction queue and the ID-side consumer.
// The queue connects through the slave modport; the driver/consumer side uses master.
interface id_inst_queue_if #(
   parameter int DEPTH   = 4,
   parameter int PC_WD   = 32,
   parameter int INST_WD = 32
);
   logic                     flush;
   logic                     in_valid;
   logic [PC_WD-1:0]         in_pc;
   logic [INST_WD-1:0]       in_inst;
   logic                     in_ready;
   logic                     almost_full;
   logic                     out_valid;
   logic [PC_WD-1:0]         out_pc;
   logic [INST_WD-1:0]       out_inst;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  in_ready, almost_full, out_valid, out_pc, out_inst, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output in_ready, almost_full, out_valid, out_pc, out_inst, count
   );
endinterface

// File: rtl/id_inst_queue.sv
// First-word fall-through {pc, inst} queue between IF and ID; holds fetched
// instructions across ID stalls, supports flush and gives IF an early throttle.
module id_inst_queue #(
   parameter int DEPTH     = 4,
   parameter int PC_WD     = 32,
   parameter int INST_WD   = 32,
   parameter int AF_MARGIN = 1
) (
   input logic              clk,
   input logic              rst,
   id_inst_queue_if.slave   q
);
   localparam int PTR_WD   = $clog2(DEPTH);
   localparam int CNT_WD   = PTR_WD + 1;
   localparam int ENTRY_WD = PC_WD + INST_WD;

   logic [ENTRY_WD-1:0] mem_q [DEPTH];
   logic [ENTRY_WD-1:0] mem_d [DEPTH];
   logic [PTR_WD-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WD-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_WD-1:0]   count_q, count_d;

   logic in_ready;
   logic out_valid;
   logic enq;
   logic deq;

   assign in_ready  = (count_q != CNT_WD'(DEPTH));
   assign out_valid = (count_q != '0);
   assign enq       = q.in_valid && in_ready && !q.flush;
   assign deq       = out_valid && q.out_ready && !q.flush;

   // Flush clears only pointers and count; stale payload stays but is unreachable.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            mem_d[wr_ptr_q] = {q.in_pc, q.in_inst};
            wr_ptr_d        = wr_ptr_q + PTR_WD'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_WD'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_WD'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CNT_WD'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign q.in_ready    = in_ready;
   assign q.almost_full = (count_q >= CNT_WD'(DEPTH - AF_MARGIN));
   assign q.out_valid   = out_valid;
   assign q.out_pc      = out_valid ? mem_q[rd_ptr_q][ENTRY_WD-1:INST_WD] : '0;
   assign q.out_inst    = out_valid ? mem_q[rd_ptr_q][INST_WD-1:0] : '0;
   assign q.count       = count_q;
endmodule
